// File: rtl/key_expansion_if.sv
// Signal bundle between the AES-128 key-expansion engine and its neighbours.
// The rcon ROM, the S-boxes and the round-key store all connect here; KEYEXP_STORE_EN adds the read port.
interface key_expansion_if;
  logic         start;
  logic [127:0] key_in;
  logic [7:0]   rcon_addr;
  logic [31:0]  rcon_data;
  logic [31:0]  sbox_in;
  logic [31:0]  sbox_out;
  logic         busy;
  logic         done;
  logic         word_we;
  logic [5:0]   word_addr;
  logic [31:0]  word_data;
`ifdef KEYEXP_STORE_EN
  logic [5:0]   rd_addr;
  logic [31:0]  rd_data;

  modport master (
    input  start, key_in, rcon_data, sbox_out, rd_addr,
    output rcon_addr, sbox_in, busy, done, word_we, word_addr, word_data, rd_data
  );
  modport slave (
    output start, key_in, rcon_data, sbox_out, rd_addr,
    input  rcon_addr, sbox_in, busy, done, word_we, word_addr, word_data, rd_data
  );
`else
  modport master (
    input  start, key_in, rcon_data, sbox_out,
    output rcon_addr, sbox_in, busy, done, word_we, word_addr, word_data
  );
  modport slave (
    output start, key_in, rcon_data, sbox_out,
    input  rcon_addr, sbox_in, busy, done, word_we, word_addr, word_data
  );
`endif
endinterface

// File: rtl/key_expansion.sv
// Sequential AES-128 key expansion: emits w[0..43] one word per clock from a 4-word sliding window.
// Define KEYEXP_STORE_EN to add a 44x32 round-key array with a registered read port.
module key_expansion #(
  parameter int NK     = 4,
  parameter int NWORDS = 44
) (
  input logic            clk,
  input logic            rst,
  key_expansion_if.master kx
);

  localparam logic [5:0] LAST_KEY = 6'(NK - 1);
  localparam logic [5:0] LAST_IDX = 6'(NWORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_EXPAND,
    S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic [5:0]        idx_q, idx_d;
  logic [3:0][31:0]  win_q, win_d;     // win[0] = w[i-4] ... win[3] = w[i-1]

  logic              word_we_q;
  logic [5:0]        word_addr_q;
  logic [31:0]       word_data_q;
  logic              busy_q;
  logic              done_q;

  logic              emit;
  logic [31:0]       emit_word;
  logic              finish;

  logic              is_core;
  logic [31:0]       rot_word;
  logic [31:0]       temp;
  logic [31:0]       new_word;

  // Round-function path: only live on the first word of each 4-word group.
  assign is_core  = (state_q == S_EXPAND) && (idx_q[1:0] == 2'b00);
  assign rot_word = {win_q[3][23:0], win_q[3][31:24]};
  assign temp     = is_core ? (kx.sbox_out ^ kx.rcon_data) : win_q[3];
  assign new_word = win_q[0] ^ temp;

  assign kx.sbox_in   = is_core ? rot_word : 32'h0;
  assign kx.rcon_addr = is_core ? {4'b0000, idx_q[5:2]} : 8'h00;

  // NOTE: every variable driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    win_d     = win_q;
    emit      = 1'b0;
    emit_word = 32'h0;
    finish    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (kx.start) begin
          win_d[0] = kx.key_in[127:96];
          win_d[1] = kx.key_in[95:64];
          win_d[2] = kx.key_in[63:32];
          win_d[3] = kx.key_in[31:0];
          idx_d    = 6'd0;
          state_d  = S_LOAD;
        end
      end

      S_LOAD: begin
        emit      = 1'b1;
        emit_word = win_q[idx_q[1:0]];
        idx_d     = idx_q + 6'd1;
        if (idx_q == LAST_KEY) begin
          state_d = S_EXPAND;
        end
      end

      S_EXPAND: begin
        emit      = 1'b1;
        emit_word = new_word;
        win_d     = {new_word, win_q[3:1]};
        idx_d     = idx_q + 6'd1;
        if (idx_q == LAST_IDX) begin
          idx_d   = 6'd0;
          state_d = S_FINISH;
        end
      end

      S_FINISH: begin
        finish  = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      idx_q       <= 6'd0;
      win_q       <= '0;
      word_we_q   <= 1'b0;
      word_addr_q <= 6'd0;
      word_data_q <= 32'h0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      win_q     <= win_d;
      word_we_q <= emit;
      busy_q    <= emit;
      done_q    <= finish;
      if (emit) begin
        word_addr_q <= idx_q;
        word_data_q <= emit_word;
      end
    end
  end

  assign kx.word_we   = word_we_q;
  assign kx.word_addr = word_addr_q;
  assign kx.word_data = word_data_q;
  assign kx.busy      = busy_q;
  assign kx.done      = done_q;

`ifdef KEYEXP_STORE_EN
  logic [31:0] mem_q [NWORDS];
  logic [31:0] rd_data_q;

  // NOTE: the word array has no reset; its contents are only meaningful once written.
  always_ff @(posedge clk) begin
    if (word_we_q) begin
      mem_q[word_addr_q] <= word_data_q;
    end
  end

  // A read colliding with the write of the same word sees the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= 32'h0;
    end else if (kx.rd_addr < LAST_IDX + 6'd1) begin
      rd_data_q <= mem_q[kx.rd_addr];
    end else begin
      rd_data_q <= 32'h0;
    end
  end

  assign kx.rd_data = rd_data_q;
`endif

endmodule
